bconv3x3_engine: RTL and testbench
==================================

BCONV3X3_ENGINE -- requirements
Module: bconv3x3_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning input frame width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 28, meaning input frame height in pixels (>=3).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port weight_en  input  1  weight bit valid strobe.
REQ-006 SHALL have port weight_din  input  1  binary weight bit (1 = +1, 0 = -1).
REQ-007 SHALL have port start  input  1  pixel valid strobe, level, held by the sender while streaming.
REQ-008 SHALL have port din  input  1  binary pixel bit, raster order (1 = +1, 0 = -1).
REQ-009 SHALL have port result  output  5  signed convolution output, two's complement.
REQ-010 SHALL have port result_valid  output  1  one-cycle qualifier for result.
REQ-011 SHALL have port done  output  1  sticky frame-complete flag.

Function
REQ-012 SHALL implement states IDLE, LOAD, READY, RUN, FLUSH, DONE.
REQ-013 IDLE: weight_en=1 -> LOAD, with that cycle's bit counted as weight bit 0.
REQ-014 LOAD: each cycle with weight_en=1 SHALL shift weight_din into 9-bit w (new bit in LSB), increment wcnt (0..8); the cycle the 9th bit is accepted -> READY; weight_en=0 holds w and wcnt.
REQ-015 After load, first bit received SHALL sit in w[8] = window top-left; last bit in w[0] = bottom-right; row-major.
REQ-016 READY/RUN: a pixel SHALL be accepted in any cycle with start=1 and weight_en=0; first accept moves READY -> RUN.
REQ-017 start=0 in RUN SHALL stall: col/row counters, line buffers, window unchanged, no result_valid.
REQ-018 weight_en SHALL be ignored in READY, RUN and FLUSH; pixels SHALL be ignored in IDLE, LOAD, FLUSH and DONE.
REQ-019 Each accept SHALL advance col 0..IMG_W-1, wrapping to 0 and incrementing row 0..IMG_H-1.
REQ-020 SHALL keep two IMG_W-bit line buffers (rows r-1, r-2) plus a 3x3 window shift register, updated only on accept.
REQ-021 On accept of pixel (r,c) with r>=2 and c>=2, the window SHALL be rows r-2..r, cols c-2..c, and a result SHALL be produced.
REQ-022 result SHALL equal 2*popcount(~(window XOR w)) - 9, range -9..+9, registered; result_valid=1 the cycle after the accept.
REQ-023 Windows with r<2 or c<2 SHALL NOT produce result_valid; columns SHALL NOT wrap across row boundaries.
REQ-024 Exactly (IMG_W-2)*(IMG_H-2) results per frame (676 for defaults), strictly raster order.
REQ-025 Accept of pixel (IMG_H-1, IMG_W-1) -> FLUSH; FLUSH presents final result (result_valid=1) -> DONE.
REQ-026 done SHALL rise on entry to DONE (cycle after the last result_valid) and stay 1 until DONE exits.
REQ-027 DONE: weight_en=1 -> LOAD, clearing done, row, col, wcnt in the same edge; that bit counts as weight bit 0.
REQ-028 result SHALL hold its last value when result_valid=0.

Reset
REQ-029 rstn=0 SHALL asynchronously force state=IDLE, result=0, result_valid=0, done=0, w=0, wcnt=0, row=0, col=0, line buffers and window=0.
REQ-030 Reset mid-LOAD or mid-RUN SHALL abort the frame; after release no result_valid until a full 9-bit load and new pixels.

Verification
REQ-031 Load 9 ones, stream 784 ones (start held) -> 676 pulses, each result=+9 (5'b01001); done=1 one cycle after the 676th.
REQ-032 Load 9 ones, stream 784 zeros -> 676 results of -9 (5'b10111); first result_valid exactly one cycle after accept of pixel (2,2), i.e. the 59th accept.
REQ-033 Load weights 1,0,1,0,1,0,1,0,1, stream checkerboard din=(r+c)%2==0 -> result alternates +9 at even (r+c), -9 at odd (r+c) of window bottom-right.
REQ-034 Toggle start randomly in RUN (50% duty) -> same 676 values as REQ-031 in order, no result_valid during stall cycles.
REQ-035 Assert rstn=0 after 300 pixels, reload, stream full frame -> exactly 676 correct results, none from the aborted frame.
REQ-036 In DONE, assert weight_en for 9 cycles -> done clears on first edge, state READY after 9th bit; second frame completes normally.

Source files
------------

// File: rtl/bconv3x3_engine.sv
// Binary 3x3 convolution engine: loads nine +/-1 weights serially, then streams a
// binary frame in raster order and emits one signed XNOR-popcount result per full window.
module bconv3x3_engine #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       weight_en,
   input  logic       weight_din,
   input  logic       start,
   input  logic       din,
   output logic [4:0] result,
   output logic       result_valid,
   output logic       done
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StReady,
      StRun,
      StFlush,
      StDone
   } state_e;

   state_e           r_state;
   state_e           w_state_nxt;

   logic [8:0]       r_w;
   logic [3:0]       r_wcnt;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [IMG_W-1:0] r_lb1;   // row r-1
   logic [IMG_W-1:0] r_lb2;   // row r-2
   logic [8:0]       r_win;   // [8] = top-left, [0] = bottom-right
   logic [4:0]       r_result;
   logic             r_result_valid;

   logic             w_wt_acc;
   logic             w_px_acc;
   logic             w_last_px;
   logic             w_win_ok;
   logic [8:0]       w_win_nxt;
   logic [3:0]       w_pc;
   logic [4:0]       w_res;

   assign w_wt_acc  = weight_en && (r_state inside {StIdle, StLoad, StDone});
   assign w_px_acc  = start && !weight_en && (r_state inside {StReady, StRun});
   assign w_last_px = (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_win_ok  = (r_row >= RW'(2)) && (r_col >= CW'(2));

   // Window after this accept: each row shifts left, new column comes from the line buffers.
   assign w_win_nxt = {r_win[7:6], r_lb2[r_col],
                       r_win[4:3], r_lb1[r_col],
                       r_win[1:0], din};

   // Count matching (XNOR) bits between the incoming window and the weights.
   always_comb begin
      w_pc = '0;
      for (int i = 0; i < 9; i++) begin
         w_pc = w_pc + {3'b000, ~(w_win_nxt[i] ^ r_w[i])};
      end
   end

   // 2*matches - 9, wrapped to 5-bit two's complement.
   assign w_res = {w_pc, 1'b0} - 5'd9;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (weight_en) w_state_nxt = StLoad;
         StLoad:  if (weight_en && (r_wcnt == 4'd8)) w_state_nxt = StReady;
         StReady: if (w_px_acc) w_state_nxt = StRun;
         StRun:   if (w_px_acc && w_last_px) w_state_nxt = StFlush;
         StFlush: w_state_nxt = StDone;
         StDone:  if (weight_en) w_state_nxt = StLoad;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Serial weight load; the bit arriving in IDLE/DONE is weight bit 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_w    <= '0;
         r_wcnt <= '0;
      end else if (w_wt_acc) begin
         r_w <= {r_w[7:0], weight_din};
         if (r_state == StLoad) begin
            r_wcnt <= (r_wcnt == 4'd8) ? 4'd0 : r_wcnt + 4'd1;
         end else begin
            r_wcnt <= 4'd1;
         end
      end
   end

   // Pixel position, line buffers and window advance only on accepted pixels.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_col <= '0;
         r_row <= '0;
         r_lb1 <= '0;
         r_lb2 <= '0;
         r_win <= '0;
      end else if ((r_state == StDone) && weight_en) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_px_acc) begin
         r_win        <= w_win_nxt;
         r_lb2[r_col] <= r_lb1[r_col];
         r_lb1[r_col] <= din;
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Registered result; value holds while no new window completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (w_px_acc && w_win_ok) begin
            r_result       <= w_res;
            r_result_valid <= 1'b1;
         end
      end
   end

   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign done         = (r_state == StDone);

endmodule

// File: tb/tb_bconv3x3_engine.sv
// Scoreboard bench for bconv3x3_engine: a frame-image model computes each expected
// window sum directly; the monitor pops expectations as result_valid pulses appear.
module tb_bconv3x3_engine;

   localparam int W     = 28;
   localparam int H     = 28;
   localparam int FRAME = W * H;
   localparam int NRES  = (W - 2) * (H - 2);

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       weight_en = 1'b0;
   logic       weight_din = 1'b0;
   logic       start = 1'b0;
   logic       din = 1'b0;
   logic [4:0] result;
   logic       result_valid;
   logic       done;

   bconv3x3_engine #(
      .IMG_W(W),
      .IMG_H(H)
   ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .weight_en   (weight_en),
      .weight_din  (weight_din),
      .start       (start),
      .din         (din),
      .result      (result),
      .result_valid(result_valid),
      .done        (done)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_miss = 0;
   int         n_res = 0;
   bit         img[H][W];
   bit         wt[9];          // wt[0] = first loaded = top-left
   logic [4:0] exp_q[$];
   logic [4:0] last_res = 5'd0;
   logic       drv_win = 1'b0;
   logic       exp_vld;

   // A result is due the cycle after an accepted pixel that completes a window.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) exp_vld <= 1'b0;
      else       exp_vld <= drv_win;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_res(input int r, input int c);
      int s = 0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            s += (img[r-2+dr][c-2+dc] == wt[dr*3+dc]) ? 1 : -1;
      return 5'(s);
   endfunction

   function automatic bit pat_px(input int pat, input int r, input int c);
      case (pat)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return ((r + c) % 2) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor_body();
      logic [4:0] e;
      if (!rstn) begin
         exp_q.delete();
         last_res = 5'd0;
      end else begin
         if (result_valid || exp_vld) check_val("valid", 32'(result_valid), 32'(exp_vld));
         if (result_valid) begin
            check_val("pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_val("result", 32'(result), 32'(e));
               last_res = e;
               n_res++;
            end
         end else begin
            check_val("hold", 32'(result), 32'(last_res));
         end
      end
   endtask

   // bits[8] is sent first; one gap cycle mid-load with pixel noise that must be ignored.
   task automatic load_w(input logic [8:0] bits);
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            weight_en  = 1'b0;
            weight_din = 1'($urandom_range(0, 1));
            start      = 1'b1;
            din        = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
         end
         weight_en  = 1'b1;
         weight_din = bits[8-i];
         wt[i]      = bits[8-i];
         step();
         if (i == 0) check_val("done_clr", 32'(done), 32'd0);
      end
      weight_en = 1'b0;
   endtask

   task automatic drive_pixel(input bit px, input int r, input int c);
      weight_en = 1'b0;
      start     = 1'b1;
      din       = px;
      img[r][c] = px;
      drv_win   = (r >= 2) && (c >= 2);
      if (drv_win) exp_q.push_back(exp_res(r, c));
      step();
      start   = 1'b0;
      drv_win = 1'b0;
   endtask

   task automatic run_frame(input int pat, input bit stalls, input int npix);
      int n0 = n_res;
      for (int idx = 0; idx < npix; idx++) begin
         if (stalls) begin
            for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) begin
               // Stall cycle: either no start, or start masked by weight_en.
               weight_en  = 1'($urandom_range(0, 1));
               start      = weight_en ? 1'($urandom_range(0, 1)) : 1'b0;
               din        = 1'($urandom_range(0, 1));
               weight_din = 1'($urandom_range(0, 1));
               step();
               weight_en = 1'b0;
               start     = 1'b0;
            end
         end
         drive_pixel(pat_px(pat, idx / W, idx % W), idx / W, idx % W);
      end
      if (npix == FRAME) begin
         check_val("done_flush", 32'(done), 32'd0);
         step();
         check_val("done_set", 32'(done), 32'd1);
         check_val("n_results", 32'(n_res - n0), 32'(NRES));
         check_val("q_drained", 32'(exp_q.size()), 32'd0);
         start = 1'b1;  // pixels ignored in DONE
         step();
         step();
         start = 1'b0;
         check_val("done_sticky", 32'(done), 32'd1);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      check_val("rst_result", 32'(result), 32'd0);
      check_val("rst_valid", 32'(result_valid), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      step();
      step();
      rstn = 1'b1;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            monitor_body();
         end
      join_none

      do_reset();
      step();

      // All-ones weights and pixels: every result +9.
      load_w(9'h1FF);
      run_frame(0, 1'b0, FRAME);

      // Reload from DONE, all-zero pixels: every result -9.
      load_w(9'h1FF);
      run_frame(1, 1'b0, FRAME);

      // Alternating weights against a checkerboard: +9/-9 by parity of (r+c).
      load_w(9'b101010101);
      run_frame(2, 1'b0, FRAME);

      // Random stalls, with masked starts, on the all-ones frame.
      load_w(9'h1FF);
      run_frame(0, 1'b1, FRAME);

      // Abort a random frame mid-stream; ignored pixels in IDLE; then a full new frame.
      load_w(9'($urandom()));
      run_frame(3, 1'b0, 300);
      do_reset();
      start = 1'b1;
      din   = 1'b1;
      for (int i = 0; i < 4; i++) step();
      start = 1'b0;
      load_w(9'($urandom()));
      run_frame(3, 1'b1, FRAME);

      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
